// File: rtl/ram_2r1w_sched_pkg.sv
// Shared constants and types for the 2R1W RAM request scheduler.
package ram_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 6;
    localparam int DEF_DATA_W  = 8;

    // Read port a granted requester was served on; routes its response data.
    typedef enum logic {
        PORT1 = 1'b0,
        PORT2 = 1'b1
    } port_sel_e;

endpackage

// File: rtl/ram_2r1w_sched_rr_pick.sv
// Round-robin find-first: returns the first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             found_o,
    output logic [PTR_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] pos;

    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        sum      = '0;
        pos      = '0;
        for (int k = 0; k < N; k++) begin
            // ptr_i + k is below 2*N, so one conditional subtract is the modulo
            sum = {1'b0, ptr_i} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N)) begin
                sum = sum - (PTR_W + 1)'(N);
            end
            pos = sum[PTR_W-1:0];
            if (!found_o && req_i[pos]) begin
                found_o       = 1'b1;
                idx_o         = pos;
                onehot_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_2r1w_sched.sv
// Schedules NUM_REQ requesters onto a 2-read/1-write synchronous RAM with round-robin fairness.
// Define RAM_SCHED_BYPASS_EN to forward same-cycle write data to reads of the same address.
module ram_2r1w_sched
    import ram_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic                      ram_en,
    output logic                      ram_wr_en,
    output logic [ADDR_W-1:0]         ram_wr_addr,
    output logic [ADDR_W-1:0]         ram_rd_addr1,
    output logic [ADDR_W-1:0]         ram_rd_addr2,
    output logic [DATA_W-1:0]         ram_wr_data,
    input  logic [DATA_W-1:0]         ram_rd_data1,
    input  logic [DATA_W-1:0]         ram_rd_data2
);

    localparam int PTR_W = $clog2(NUM_REQ);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    logic                ram_en_q;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   rd_addr1_q, rd_addr1_d;
    logic [ADDR_W-1:0]   rd_addr2_q, rd_addr2_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    port_sel_e           rsp_port_q [NUM_REQ];
    port_sel_e           rsp_port_d [NUM_REQ];

    logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_a [NUM_REQ];

    logic [NUM_REQ-1:0]  wr_cand, rd_cand, rd2_cand;
    logic                wr_found, rd1_found, rd2_found;
    logic [PTR_W-1:0]    wr_idx, rd1_idx, rd2_idx;
    logic [NUM_REQ-1:0]  wr_oh, rd1_oh, rd2_oh;
    logic [DATA_W-1:0]   port1_data, port2_data;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // ---- grant stage: arbitration is combinational and consumed this cycle
    assign wr_cand  = req_valid &  req_we & {NUM_REQ{ram_en_q}};
    assign rd_cand  = req_valid & ~req_we & {NUM_REQ{ram_en_q}};
    assign rd2_cand = rd_cand & ~rd1_oh;

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_wr (
        .req_i    (wr_cand),
        .ptr_i    (wr_ptr_q),
        .found_o  (wr_found),
        .idx_o    (wr_idx),
        .onehot_o (wr_oh)
    );

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_rd1 (
        .req_i    (rd_cand),
        .ptr_i    (rd_ptr_q),
        .found_o  (rd1_found),
        .idx_o    (rd1_idx),
        .onehot_o (rd1_oh)
    );

    // Same start point with the first winner masked yields the second hit in order.
    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick_rd2 (
        .req_i    (rd2_cand),
        .ptr_i    (rd_ptr_q),
        .found_o  (rd2_found),
        .idx_o    (rd2_idx),
        .onehot_o (rd2_oh)
    );

    assign gnt = wr_oh | rd1_oh | rd2_oh;

    always_comb begin
        ram_wr_en   = wr_found;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        if (wr_found) begin
            ram_wr_addr = addr_a[wr_idx];
            ram_wr_data = wdata_a[wr_idx];
        end

        rd_addr1_d = rd1_found ? addr_a[rd1_idx] : rd_addr1_q;
        rd_addr2_d = rd2_found ? addr_a[rd2_idx] : rd_addr2_q;

        wr_ptr_d = wr_found ? ptr_inc(wr_idx) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (rd2_found) begin
            rd_ptr_d = ptr_inc(rd2_idx);
        end else if (rd1_found) begin
            rd_ptr_d = ptr_inc(rd1_idx);
        end

        rsp_valid_d = rd1_oh | rd2_oh;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_port_d[i] = rd2_oh[i] ? PORT2 : PORT1;
        end
    end

    assign ram_en       = ram_en_q;
    assign ram_rd_addr1 = rd_addr1_d;
    assign ram_rd_addr2 = rd_addr2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_addr1_q  <= '0;
            rd_addr2_q  <= '0;
            rsp_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_port_q[i] <= PORT1;
            end
        end else begin
            ram_en_q    <= 1'b1;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_addr1_q  <= rd_addr1_d;
            rd_addr2_q  <= rd_addr2_d;
            rsp_valid_q <= rsp_valid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_port_q[i] <= rsp_port_d[i];
            end
        end
    end

    // ---- response stage: RAM data arrives one cycle after the grant
`ifdef RAM_SCHED_BYPASS_EN
    logic              byp1_q, byp1_d;
    logic              byp2_q, byp2_d;
    logic [DATA_W-1:0] byp_data_q;

    assign byp1_d = wr_found && rd1_found && (ram_wr_addr == rd_addr1_d);
    assign byp2_d = wr_found && rd2_found && (ram_wr_addr == rd_addr2_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp1_q     <= byp1_d;
            byp2_q     <= byp2_d;
            byp_data_q <= ram_wr_data;
        end
    end

    assign port1_data = byp1_q ? byp_data_q : ram_rd_data1;
    assign port2_data = byp2_q ? byp_data_q : ram_rd_data2;
`else
    assign port1_data = ram_rd_data1;
    assign port2_data = ram_rd_data2;
`endif

    assign rsp_valid = rsp_valid_q;

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_data[i*DATA_W +: DATA_W] = (rsp_port_q[i] == PORT2) ? port2_data : port1_data;
        end
    end

endmodule

// File: tb/tb_ram_2r1w_sched.sv
// Directed and randomized bench for ram_2r1w_sched against a behavioural scheduler/RAM model.
`timescale 1ns/1ps
module tb_ram_2r1w_sched;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      req_valid, req_we;
    logic [AW-1:0]     a  [N];
    logic [DW-1:0]     wd [N];
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      gnt, rsp_valid;
    logic [N*DW-1:0]   rsp_data;
    logic              ram_en, ram_wr_en;
    logic [AW-1:0]     ram_wr_addr, ram_rd_addr1, ram_rd_addr2;
    logic [DW-1:0]     ram_wr_data;
    logic [DW-1:0]     ram_rd_data1 = '0;
    logic [DW-1:0]     ram_rd_data2 = '0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*AW +: AW]  = a[g];
        assign req_wdata[g*DW +: DW] = wd[g];
    end

    ram_2r1w_sched #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .ram_en       (ram_en),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_rd_addr1 (ram_rd_addr1),
        .ram_rd_addr2 (ram_rd_addr2),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_data1 (ram_rd_data1),
        .ram_rd_data2 (ram_rd_data2)
    );

    // 64x8 2R1W synchronous RAM; a same-address read returns the old word.
    logic [DW-1:0] ram [64] = '{default: '0};
    always @(posedge clk) begin
        ram_rd_data1 <= ram[ram_rd_addr1];
        ram_rd_data2 <= ram[ram_rd_addr2];
        if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    end

    // Reference model state
    logic [DW-1:0] mm [64];
    int            wptr, rptr;
    bit            m_en;
    bit [N-1:0]    exp_rv;
    logic [DW-1:0] exp_rd [N];
    logic [AW-1:0] m_ra1, m_ra2;
    int            last_wi;
    logic [N-1:0]  gnt_acc;
    int            wait_cnt [N];
    int            max_wait;
    int            checks = 0;
    int            errors = 0;
    int            seq [6];

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_en   = 1'b0;
        wptr   = 0;
        rptr   = 0;
        exp_rv = '0;
        m_ra1  = '0;
        m_ra2  = '0;
    endtask

    function automatic logic [DW-1:0] rd_expect(input int r, input int wi);
`ifdef RAM_SCHED_BYPASS_EN
        if (wi >= 0 && a[wi] == a[r]) return wd[wi];
`endif
        return mm[a[r]];
    endfunction

    // One clock: check outputs at negedge against the model, advance the model, cross posedge.
    task automatic cycle(input bit rst_after);
        logic [N-1:0]  eg;
        logic [AW-1:0] ea1, ea2;
        int wi, r1, r2, idx;
        @(negedge clk);
        chk(32'(ram_en), 32'(m_en), "ram_en");
        for (int i = 0; i < N; i++) begin
            chk(32'(rsp_valid[i]), 32'(exp_rv[i]), $sformatf("rsp_valid[%0d]", i));
            if (exp_rv[i]) chk(32'(rsp_data[i*DW +: DW]), 32'(exp_rd[i]), $sformatf("rsp_data[%0d]", i));
        end
        eg = '0; wi = -1; r1 = -1; r2 = -1;
        if (m_en) begin
            for (int k = 0; k < N; k++) begin
                idx = (wptr + k) % N;
                if (wi < 0 && req_valid[idx] && req_we[idx]) wi = idx;
                idx = (rptr + k) % N;
                if (req_valid[idx] && !req_we[idx]) begin
                    if (r1 < 0) r1 = idx;
                    else if (r2 < 0) r2 = idx;
                end
            end
        end
        if (wi >= 0) eg[wi] = 1'b1;
        if (r1 >= 0) eg[r1] = 1'b1;
        if (r2 >= 0) eg[r2] = 1'b1;
        chk(32'(gnt), 32'(eg), "gnt");
        chk(32'(ram_wr_en), 32'(wi >= 0), "ram_wr_en");
        if (wi >= 0) begin
            chk(32'(ram_wr_addr), 32'(a[wi]), "ram_wr_addr");
            chk(32'(ram_wr_data), 32'(wd[wi]), "ram_wr_data");
        end
        ea1 = (r1 >= 0) ? a[r1] : m_ra1;
        ea2 = (r2 >= 0) ? a[r2] : m_ra2;
        chk(32'(ram_rd_addr1), 32'(ea1), "ram_rd_addr1");
        chk(32'(ram_rd_addr2), 32'(ea2), "ram_rd_addr2");

        exp_rv = '0;
        if (r1 >= 0) begin exp_rv[r1] = 1'b1; exp_rd[r1] = rd_expect(r1, wi); end
        if (r2 >= 0) begin exp_rv[r2] = 1'b1; exp_rd[r2] = rd_expect(r2, wi); end
        if (wi >= 0) begin mm[a[wi]] = wd[wi]; wptr = (wi + 1) % N; end
        if (r2 >= 0) rptr = (r2 + 1) % N;
        else if (r1 >= 0) rptr = (r1 + 1) % N;
        m_ra1 = ea1; m_ra2 = ea2;
        last_wi = wi;
        gnt_acc |= gnt;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !eg[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
        @(posedge clk);
        if (rst_after) begin
            rst_n = 1'b0;
            model_reset();
        end else begin
            m_en = (rst_n === 1'b1);
        end
        #1;
        for (int i = 0; i < N; i++) if (eg[i]) req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        model_reset();
        cycle(0);
        chk(32'(ram_wr_addr), 32'd0, "rst_wr_addr");
        chk(32'(ram_wr_data), 32'd0, "rst_wr_data");
        cycle(0);
        rst_n = 1'b1;
        cycle(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        req_valid = '0; req_we = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; wd[i] = '0; wait_cnt[i] = 0; end
        for (int i = 0; i < 64; i++) mm[i] = '0;
        max_wait = 0; gnt_acc = '0; last_wi = -1;

        // Reset values and single write then read-back
        do_reset();
        req_valid[0] = 1'b1; req_we[0] = 1'b1; a[0] = 6'h03; wd[0] = 8'h5A;
        gnt_acc = '0;
        cycle(0);
        chk(32'(gnt_acc), 32'h1, "t33_wr_gnt");
        req_valid[0] = 1'b1; req_we[0] = 1'b0; a[0] = 6'h03;
        gnt_acc = '0;
        cycle(0);
        chk(32'(gnt_acc), 32'h1, "t33_rd_gnt");
        chk(32'(rsp_valid[0]), 32'h1, "t33_rsp_valid");
        chk(32'(rsp_data[7:0]), 32'h5A, "t33_rsp_data");
        cycle(0);

        // Continuous writes from all requesters rotate 0,1,2,3,0
        do_reset();
        max_wait = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = 1'b1; req_we[i] = 1'b1;
                a[i] = AW'(6'h10 + i); wd[i] = DW'($urandom);
            end
            cycle(0);
            seq[c] = last_wi;
        end
        req_valid = '0;
        chk(32'(seq[0]), 32'd0, "t34_rot0");
        chk(32'(seq[1]), 32'd1, "t34_rot1");
        chk(32'(seq[2]), 32'd2, "t34_rot2");
        chk(32'(seq[3]), 32'd3, "t34_rot3");
        chk(32'(seq[4]), 32'd0, "t34_rot4");
        chk(32'(max_wait <= 3), 32'd1, "t34_max_wait");

        // Preload 0..3, then four simultaneous reads served two per cycle
        for (int i = 0; i < N; i++) begin
            req_valid[0] = 1'b1; req_we[0] = 1'b1; a[0] = AW'(i); wd[0] = DW'(8'h10 + i);
            cycle(0);
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b1; req_we[i] = 1'b0; a[i] = AW'(i);
        end
        gnt_acc = '0;
        for (int c = 0; c < 2; c++) begin
            cycle(0);
            for (int i = 0; i < N; i++)
                if (rsp_valid[i]) chk(32'(rsp_data[i*DW +: DW]), 32'(8'h10 + i), $sformatf("t35_data%0d", i));
        end
        chk(32'(gnt_acc), 32'hF, "t35_all_served");
        cycle(0);

        // Same-cycle write and read of one address
        req_valid[1] = 1'b1; req_we[1] = 1'b1; a[1] = 6'h20; wd[1] = 8'hAA;
        req_valid[2] = 1'b1; req_we[2] = 1'b0; a[2] = 6'h20;
        cycle(0);
        chk(32'(rsp_valid[2]), 32'h1, "t36_rsp_valid");
`ifdef RAM_SCHED_BYPASS_EN
        chk(32'(rsp_data[23:16]), 32'hAA, "t36_rsp_data");
`else
        chk(32'(rsp_data[23:16]), 32'h00, "t36_rsp_data");
`endif
        cycle(0);

        // Reset right after a read grant: response dropped, pointers cleared
        req_valid[2] = 1'b1; req_we[2] = 1'b0; a[2] = 6'h01;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; a[1] = 6'h05; wd[1] = 8'h77;
        cycle(1);
        chk(32'(rsp_valid), 32'h0, "t37_rsp_dropped");
        chk(32'(ram_en), 32'h0, "t37_ram_en_low");
        cycle(0);
        cycle(0);
        rst_n = 1'b1;
        cycle(0);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b1; req_we[i] = 1'b1; a[i] = AW'(6'h08 + i); wd[i] = DW'(i);
        end
        cycle(0);
        chk(32'(last_wi), 32'd0, "t37_wr_ptr0");
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b1; req_we[i] = 1'b0; a[i] = AW'(i);
        end
        gnt_acc = '0;
        cycle(0);
        chk(32'(gnt_acc), 32'h3, "t37_rd_ptr0");
        cycle(0);
        cycle(0);

        // Randomized traffic over a small address window
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
                    req_valid[i] = 1'b1;
                    req_we[i]    = ($urandom_range(0, 2) == 0);
                    a[i]         = AW'($urandom_range(0, 7));
                    wd[i]        = DW'($urandom);
                end
            end
            cycle(0);
        end
        req_valid = '0;
        cycle(0);
        cycle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
